// File: rtl/bits_count_pkg.sv
// Shared definitions for the synchronous up-counter family.
//   DEFAULT_WIDTH : default counter width in bits
//   count_t       : count value type at the default width
//   max_count()   : terminal count (modulus - 1); callers size it to their width
package bits_count_pkg;

    localparam int DEFAULT_WIDTH = 3;

    typedef logic [DEFAULT_WIDTH-1:0] count_t;

    function automatic int unsigned max_count(input int unsigned modulus);
        return modulus - 1;
    endfunction

endpackage

// File: rtl/tff_sync_bit.sv
// One bit of a synchronous counter: a T flip-flop with a synchronous load path.
//   clk      : clock, state changes on posedge
//   reset    : asynchronous, active-high clear
//   toggle_i : invert the stored bit on the next edge
//   load_i   : replace the stored bit with load_d_i (wins over toggle_i)
//   load_d_i : data written when load_i is high
//   q_o      : stored bit
module tff_sync_bit (
    input  logic clk,
    input  logic reset,
    input  logic toggle_i,
    input  logic load_i,
    input  logic load_d_i,
    output logic q_o
);

    logic bit_q;

    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // pre-edge values, regardless of block evaluation order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_q <= 1'b0;
        end else if (load_i) begin
            bit_q <= load_d_i;
        end else if (toggle_i) begin
            bit_q <= ~bit_q;
        end
    end

    assign q_o = bit_q;

endmodule

// File: rtl/bits3countincrease_sync.sv
// Synchronous modulo-MODULUS up counter built from WIDTH T flip-flops that all
// clock on the same edge. Supports enable, clamped parallel load, a
// combinational terminal count for cascading and a registered wrap pulse.
//   clk      : clock
//   reset    : asynchronous, active-high; clears Q and wrap
//   en       : count enable
//   load     : synchronous parallel load, priority over en
//   load_val : load data, clamped to MODULUS-1
//   Q        : current count
//   tc       : en & (Q == MODULUS-1), feeds the next stage's en
//   wrap     : one-cycle pulse during the cycle after Q rolls over to 0
// Build option: define BITS3COUNTINCREASE_SAT_EN for saturating mode (Q holds
// at MODULUS-1, wrap never asserts).
module bits3countincrease_sync
    import bits_count_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int MODULUS = 2**WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] Q,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(max_count(MODULUS));

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] toggle;
    logic [WIDTH-1:0] clamp_val;
    logic [WIDTH-1:0] load_d;
    logic             at_max;
    logic             roll;
    logic             en_cnt;
    logic             bit_load;
    logic             carry;
    logic             wrap_d;
    logic             wrap_q;

    assign at_max    = (count_q == MAX_Q);
    assign tc        = en & at_max;
    assign clamp_val = (load_val > MAX_Q) ? MAX_Q : load_val;

`ifdef BITS3COUNTINCREASE_SAT_EN
    // At the terminal count the toggles are suppressed, so Q sticks at max.
    assign roll   = 1'b0;
    assign en_cnt = en & ~at_max;
`else
    // A non-power-of-two modulus cannot roll over by toggling alone, so the
    // rollover to zero goes through every bit's load path.
    assign roll   = en & ~load & at_max;
    assign en_cnt = en;
`endif

    assign bit_load = load | roll;
    assign load_d   = load ? clamp_val : '0;
    assign wrap_d   = roll;

    // Bit i toggles when counting and all lower bits are 1.
    // NOTE: every variable written here gets a value before any branch or
    // loop, so no latch can be inferred.
    always_comb begin
        toggle = '0;
        carry  = en_cnt;
        for (int i = 0; i < WIDTH; i++) begin
            toggle[i] = carry;
            carry     = carry & count_q[i];
        end
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_bit
        tff_sync_bit u_bit (
            .clk      (clk),
            .reset    (reset),
            .toggle_i (toggle[g]),
            .load_i   (bit_load),
            .load_d_i (load_d[g]),
            .q_o      (count_q[g])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= wrap_d;
        end
    end

    assign Q    = count_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_bits3countincrease_sync.sv
module tb_bits3countincrease_sync;

`ifdef BITS3COUNTINCREASE_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef struct {
        bit en;
        bit load;
        int lv;
        bit tc;   // expected tc before the edge
        int q;    // expected Q after the edge
        bit w;    // expected wrap after the edge
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       en8, ld8, en6, ld6, en_c0;
    logic [2:0] lv8, lv6;
    logic [2:0] q8, q6, q_c0, q_c1;
    logic       tc8, tc6, tc_c0, tc_c1;
    logic       w8, w6, w_c0, w_c1;
    logic       zero_bit;
    logic [2:0] zero_val;

    int n_checks = 0;
    int n_fail   = 0;
    int m8q, m6q;
    bit m8w, m6w;

    bits3countincrease_sync #(.WIDTH(3), .MODULUS(8)) u8 (
        .clk(clk), .reset(reset), .en(en8), .load(ld8), .load_val(lv8),
        .Q(q8), .tc(tc8), .wrap(w8));

    bits3countincrease_sync #(.WIDTH(3), .MODULUS(6)) u6 (
        .clk(clk), .reset(reset), .en(en6), .load(ld6), .load_val(lv6),
        .Q(q6), .tc(tc6), .wrap(w6));

    bits3countincrease_sync #(.WIDTH(3), .MODULUS(8)) c0 (
        .clk(clk), .reset(reset), .en(en_c0), .load(zero_bit), .load_val(zero_val),
        .Q(q_c0), .tc(tc_c0), .wrap(w_c0));

    bits3countincrease_sync #(.WIDTH(3), .MODULUS(8)) c1 (
        .clk(clk), .reset(reset), .en(tc_c0), .load(zero_bit), .load_val(zero_val),
        .Q(q_c1), .tc(tc_c1), .wrap(w_c1));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: one clock edge of a modulo-m counter, straight from the rules.
    task automatic model_step(input int m, input bit e, input bit l, input int lv,
                              inout int q, output bit w);
        w = 1'b0;
        if (l) begin
            q = (lv > m - 1) ? m - 1 : lv;
        end else if (e) begin
            if (q == m - 1) begin
                if (!SAT) begin
                    q = 0;
                    w = 1'b1;
                end
            end else begin
                q = q + 1;
            end
        end
    endtask

    // Apply inputs to u8/u6 for one edge and compare against the model.
    task automatic drive(input bit e8, input bit l8, input int v8,
                         input bit e6, input bit l6, input int v6, input bit cmp6);
        en8 = e8; ld8 = l8; lv8 = 3'(v8);
        en6 = e6; ld6 = l6; lv6 = 3'(v6);
        #1;
        check("tc8", tc8, (e8 && m8q == 7));
        if (cmp6) check("tc6", tc6, (e6 && m6q == 5));
        @(posedge clk);
        #1;
        model_step(8, e8, l8, v8, m8q, m8w);
        model_step(6, e6, l6, v6, m6q, m6w);
        check("q8", q8, m8q);
        check("wrap8", w8, m8w);
        if (cmp6) begin
            check("q6", q6, m6q);
            check("wrap6", w6, m6w);
        end
    endtask

    vec_t tbl [15];
    int   exp_comb, wraps_c1, q0e, q1e;

    initial begin
        zero_bit = 1'b0; zero_val = '0;
        en8 = 0; ld8 = 0; lv8 = 0; en6 = 0; ld6 = 0; lv6 = 0; en_c0 = 0;
        m8q = 0; m6q = 0; m8w = 0; m6w = 0;

        // Reset state
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset_q8", q8, 0);
        check("reset_wrap8", w8, 0);
        check("reset_q6", q6, 0);
        check("reset_cascade", {q_c1, q_c0}, 0);

        // MODULUS=8: ten enabled edges from zero
        for (int i = 0; i < 10; i++) drive(1, 0, 0, 0, 0, 0, 1);
        check("seq8_end", q8, SAT ? 7 : 2);

        // MODULUS=6: table of count, clamp and load-priority vectors
        tbl[0]  = '{1, 0, 0, 0, 1, 0};
        tbl[1]  = '{1, 0, 0, 0, 2, 0};
        tbl[2]  = '{1, 0, 0, 0, 3, 0};
        tbl[3]  = '{1, 0, 0, 0, 4, 0};
        tbl[4]  = '{1, 0, 0, 0, 5, 0};
        tbl[5]  = '{1, 0, 0, 1, SAT ? 5 : 0, !SAT};
        tbl[6]  = '{0, 0, 0, 0, SAT ? 5 : 0, 0};
        tbl[7]  = '{0, 1, 7, 0, 5, 0};
        tbl[8]  = '{1, 0, 0, 1, SAT ? 5 : 0, !SAT};
        tbl[9]  = '{1, 1, 2, SAT, 2, 0};
        tbl[10] = '{0, 1, 5, 0, 5, 0};
        tbl[11] = '{1, 1, 0, 1, 0, 0};
        tbl[12] = '{0, 1, 6, 0, 5, 0};
        tbl[13] = '{0, 0, 0, 0, 5, 0};
        tbl[14] = '{1, 0, 0, 1, SAT ? 5 : 0, !SAT};
        // u6 is still at zero from reset
        for (int i = 0; i < 15; i++) begin
            en8 = 0; ld8 = 0; lv8 = 0;
            en6 = tbl[i].en; ld6 = tbl[i].load; lv6 = 3'(tbl[i].lv);
            #1;
            check($sformatf("tbl%0d_tc", i), tc6, tbl[i].tc);
            @(posedge clk);
            #1;
            model_step(8, 0, 0, 0, m8q, m8w);
            model_step(6, tbl[i].en, tbl[i].load, tbl[i].lv, m6q, m6w);
            check($sformatf("tbl%0d_q", i), q6, tbl[i].q);
            check($sformatf("tbl%0d_wrap", i), w6, tbl[i].w);
            check("q8_idle", q8, m8q);
        end

        // Asynchronous reset between edges, with u8 at 3 and u6 pulsing wrap
        drive(0, 1, 2, 0, 1, 5, 1);
        drive(1, 0, 0, 1, 0, 0, 1);
        en8 = 1; en6 = 0;
        #2;
        reset = 1'b1;
        #1;
        check("async_q8", q8, 0);
        check("async_wrap8", w8, 0);
        check("async_q6", q6, 0);
        check("async_wrap6", w6, 0);
        #1;
        reset = 1'b0;
        m8q = 0; m6q = 0; m8w = 0; m6w = 0;
        drive(1, 0, 0, 0, 0, 0, 1);
        check("after_reset_q8", q8, 1);

        // Randomised traffic on both counters
        for (int i = 0; i < 300; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, $urandom_range(0, 7),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, $urandom_range(0, 7), 1);
        end

        // Two-stage cascade: 64 edges of stage 0 enable
        en8 = 0; ld8 = 0; en6 = 0; ld6 = 0;
        check("cascade_start", {q_c1, q_c0}, 0);
        wraps_c1 = 0;
        en_c0 = 1'b1;
        for (int k = 1; k <= 64; k++) begin
            @(posedge clk);
            #1;
            if (SAT) begin
                q0e = (k > 7) ? 7 : k;
                q1e = (k - 7 > 7) ? 7 : ((k > 7) ? k - 7 : 0);
                exp_comb = q1e * 8 + q0e;
            end else begin
                exp_comb = k % 64;
            end
            check($sformatf("cascade_k%0d", k), {q_c1, q_c0}, exp_comb);
            if (w_c1) wraps_c1++;
        end
        en_c0 = 1'b0;
        check("cascade_wraps", wraps_c1, SAT ? 0 : 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
